bpf_run_ctrl: RTL
=================

# bpf_run_ctrl

Synthesizable run controller for the BPF CPU core, parametrised in register width, register count and cycle budget. It preloads the CPU register file and PC over a valid/ready stream while holding the core in reset. It then releases the core, watches for halt against a watchdog budget, and reports result, cycle count and status. It sits between the host/bench interface and `cpu`, replacing ad-hoc hierarchical preloading with a defined load/run/report protocol.

## Interface
- `XLEN`, 32, CPU register/data width
- `NREGS`, 4, number of CPU registers; `IDX_W = $clog2(NREGS)` (min 1)
- `PC_W`, 8, program counter width
- `MAX_CYCLES`, 20, watchdog budget in RUN cycles; `CNT_W = $clog2(MAX_CYCLES+1)`

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a load/run sequence (honoured in IDLE and DONE only)
- `abort`  in  1  return to IDLE from any state
- `pc_init`  in  PC_W  start PC, sampled on accepted `start`
- `init_valid` / `init_ready`  in / out  1  register-preload handshake
- `init_idx`  in  IDX_W+1  target register (extra bit exposes out-of-range)
- `init_data`  in  XLEN  register value
- `init_last`  in  1  marks final preload beat
- `cpu_rst`  out  1  reset to core; high except in RUN
- `cpu_wr_en`, `cpu_wr_idx[IDX_W]`, `cpu_wr_data[XLEN]`  out  register write port into core
- `cpu_pc_load`, `cpu_pc_val[PC_W]`  out  PC load strobe/value
- `cpu_halt`  in  1  core halted (valid only in RUN)
- `cpu_ret`  in  XLEN  core return value (r0), sampled with halt
- `busy`, `done`, `timeout`, `idx_err`  out  1  status
- `result`  out  XLEN  latched `cpu_ret`
- `cycles`  out  CNT_W  RUN cycles consumed

## Operation
- States: IDLE, LOAD, PCLD, RUN, DONE.
- IDLE: `cpu_rst=1`, `init_ready=0`. `start`: latch `pc_init`; clear `idx_err`, `timeout`, `cycles`, `result`; go to LOAD.
- LOAD: `init_ready=1`. Each handshake registers one write. `cpu_wr_en` pulses the following cycle with latched idx/data. `init_idx >= NREGS` suppresses the write and sets sticky `idx_err`. A handshake with `init_last` goes to PCLD.
- PCLD (one cycle): `cpu_pc_load=1`, `cpu_pc_val` = latched PC. The final `cpu_wr_en` pulse coincides with this cycle. Next state is RUN.
- RUN: `cpu_rst=0`; `cycles` increments every RUN cycle.
  - `cpu_halt`: latch `cpu_ret` into `result` and go to DONE.
  - Else, when the count reaches `MAX_CYCLES`: set `timeout=1` and go to DONE.
  - Halt on the budget cycle: halt wins, `timeout=0`.
- DONE: `cpu_rst=1`, `done=1`; outputs held. `start` behaves as in IDLE and goes to LOAD.
- `abort` in any state: next state IDLE with `cpu_rst=1`. Status is left as-is, except `done` is cleared. `abort` has priority over `start`, halt and handshake.
- `start` in LOAD/PCLD/RUN is ignored.
- `busy = (state ∈ {LOAD, PCLD, RUN})`.

## Timing
- Reset values: state IDLE, `cpu_rst=1`, all other outputs 0.
- Reset mid-operation aborts immediately and asynchronously.
- `start` at edge N: `init_ready=1` from cycle N+1.
- Preload is zero-bubble: one beat per cycle sustained, `init_ready` is constant 1 in LOAD.
- Last beat accepted at edge M: PCLD during cycle M+1, RUN from M+2. `cpu_rst` falls at edge M+2.
- Halt seen at edge H: `done`, `result` and `cycles` valid from H+1; `cpu_rst` rises at H+1.
- `cycles` counts RUN cycles including the halt cycle and saturates at `MAX_CYCLES`.

## Structure
- `bpf_pkg`: state enum `run_state_t`, default `XLEN`/`NREGS`/`PC_W` constants shared with `cpu`.
- Sub-module `bpf_watchdog`:
  - Behaviour: CNT_W saturating counter with `clr`, `en`, `expired` (`count == MAX_CYCLES`).
  - Instantiation: one instance, driven by the FSM.

## Test plan
- Preload r0..r3 = 4,2,2,4, `pc_init=0`, core halts in 6 cycles with r0 = 6:
  - `cpu_wr_en` pulses idx 0..3 back-to-back, then `cpu_pc_load`.
  - `done=1`, `result=6`, `cycles=6`, `timeout=0`.
- Core never halts, `MAX_CYCLES=20` → `done=1`, `timeout=1`, `cycles=20`, `cpu_rst` high again the next cycle.
- Halt asserted exactly on cycle 20 → `timeout=0`, `result` latched, `cycles=20`.
- Beat with `init_idx=5` (NREGS=4) between valid beats → no `cpu_wr_en` for it, `idx_err=1` through DONE, other writes intact.
- `abort` in RUN at cycle 3 → IDLE next cycle, `cpu_rst=1`, `done=0`. Subsequent `start` completes normally.
- `rst` asserted mid-LOAD with `init_valid` held → outputs immediately at reset values, `init_ready=0`, no further writes.

Source files
------------

// File: rtl/bpf_pkg.sv
// Shared BPF core types and default geometry for the run controller and the CPU.
// Width helpers keep derived port widths consistent between modules.
package bpf_pkg;

  localparam int BPF_XLEN  = 32;
  localparam int BPF_NREGS = 4;
  localparam int BPF_PC_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PCLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } run_state_t;

  // Register index width, never below one bit so a single-register core still has a port.
  function automatic int idx_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/bpf_watchdog.sv
// Saturating RUN-cycle counter with synchronous clear; flags the last budget cycle
// one cycle ahead so the controller can stop exactly on the budget.
module bpf_watchdog
  import bpf_pkg::*;
#(
  parameter  int MAX_CYCLES = 20,
  localparam int CNT_W      = cnt_width(MAX_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_CNT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == MAX_CNT);
  assign at_last = (count_q == LAST_CNT);

endmodule

// File: rtl/bpf_run_ctrl.sv
// Run controller: preloads the core register file and PC over valid/ready while holding
// it in reset, then runs it against a watchdog budget and reports result/cycles/status.
module bpf_run_ctrl
  import bpf_pkg::*;
#(
  parameter  int XLEN       = BPF_XLEN,
  parameter  int NREGS      = BPF_NREGS,
  parameter  int PC_W       = BPF_PC_W,
  parameter  int MAX_CYCLES = 20,
  localparam int IDX_W      = idx_width(NREGS),
  localparam int CNT_W      = cnt_width(MAX_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc_init,
  input  logic             init_valid,
  output logic             init_ready,
  input  logic [IDX_W:0]   init_idx,
  input  logic [XLEN-1:0]  init_data,
  input  logic             init_last,
  output logic             cpu_rst,
  output logic             cpu_wr_en,
  output logic [IDX_W-1:0] cpu_wr_idx,
  output logic [XLEN-1:0]  cpu_wr_data,
  output logic             cpu_pc_load,
  output logic [PC_W-1:0]  cpu_pc_val,
  input  logic             cpu_halt,
  input  logic [XLEN-1:0]  cpu_ret,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             idx_err,
  output logic [XLEN-1:0]  result,
  output logic [CNT_W-1:0] cycles
);

  run_state_t       state_q;
  logic             cpu_rst_q;
  logic             init_ready_q;
  logic             wr_en_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [XLEN-1:0]  wr_data_q;
  logic             pc_load_q;
  logic [PC_W-1:0]  pc_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic             idx_err_q;
  logic [XLEN-1:0]  result_q;

  logic accept_start;
  logic handshake;
  logic idx_ok;
  logic wd_en;
  logic wd_expired;
  logic wd_last;
  logic wd_budget;

  assign accept_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
  assign handshake    = (state_q == ST_LOAD) && init_valid && init_ready_q;
  assign idx_ok       = ({{(31 - IDX_W){1'b0}}, init_idx} < NREGS);
  assign wd_en        = (state_q == ST_RUN) && !abort;
  // Stop on the cycle that brings the count to the budget, not one cycle later.
  assign wd_budget    = wd_last || wd_expired;

  bpf_watchdog #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_start),
    .en      (wd_en),
    .count   (cycles),
    .expired (wd_expired),
    .at_last (wd_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cpu_rst_q    <= 1'b1;
      init_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      pc_load_q    <= 1'b0;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      idx_err_q    <= 1'b0;
      result_q     <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      pc_load_q <= 1'b0;
      if (abort) begin
        state_q      <= ST_IDLE;
        cpu_rst_q    <= 1'b1;
        init_ready_q <= 1'b0;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q      <= ST_LOAD;
              pc_q         <= pc_init;
              idx_err_q    <= 1'b0;
              timeout_q    <= 1'b0;
              result_q     <= '0;
              done_q       <= 1'b0;
              busy_q       <= 1'b1;
              init_ready_q <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (handshake) begin
              wr_en_q <= idx_ok;
              if (idx_ok) begin
                wr_idx_q  <= init_idx[IDX_W-1:0];
                wr_data_q <= init_data;
              end else begin
                idx_err_q <= 1'b1;
              end
              if (init_last) begin
                state_q      <= ST_PCLD;
                init_ready_q <= 1'b0;
                pc_load_q    <= 1'b1;
              end
            end
          end
          ST_PCLD: begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b0;
          end
          ST_RUN: begin
            if (cpu_halt) begin
              state_q   <= ST_DONE;
              result_q  <= cpu_ret;
              cpu_rst_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else if (wd_budget) begin
              state_q   <= ST_DONE;
              timeout_q <= 1'b1;
              cpu_rst_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign init_ready  = init_ready_q;
  assign cpu_rst     = cpu_rst_q;
  assign cpu_wr_en   = wr_en_q;
  assign cpu_wr_idx  = wr_idx_q;
  assign cpu_wr_data = wr_data_q;
  assign cpu_pc_load = pc_load_q;
  assign cpu_pc_val  = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign idx_err     = idx_err_q;
  assign result      = result_q;

endmodule
